// File: rtl/cc_stream_pkg.sv
// cc_stream_pkg: shared stream-block types.
package cc_stream_pkg;
  typedef enum logic {IDLE, SERIAL} ser_state_e;
endpackage

// File: rtl/fifo_pop_serializer.sv
// fifo_pop_serializer: pops words from a FIFO and emits them as OUT_WIDTH beats with valid/ready.
module fifo_pop_serializer
  import cc_stream_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 fifo_empty_i,
  input  logic [IN_WIDTH-1:0]  fifo_data_i,
  output logic                 fifo_pop_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 last_o,
  output logic                 busy_o
);
  localparam int RATIO = (OUT_WIDTH > 0) ? IN_WIDTH / OUT_WIDTH : 1;
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
  if (OUT_WIDTH <= 0 || IN_WIDTH % ((OUT_WIDTH > 0) ? OUT_WIDTH : 1) != 0) begin : g_bad_width
    $error("IN_WIDTH must be a nonzero multiple of OUT_WIDTH");
  end
  ser_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, sel;
  logic [IN_WIDTH-1:0] hold_q, hold_d;
  logic fire;
  always_comb begin
    valid_o = state_q == SERIAL;
    busy_o = valid_o;
    last_o = valid_o && cnt_q == LAST;
    sel = MSB_FIRST ? LAST - cnt_q : cnt_q;
    data_o = OUT_WIDTH'(hold_q >> (OUT_WIDTH * int'(sel)));
    fire = valid_o && ready_i;
    // refill in the same cycle the last beat leaves, so words stream without a bubble
    fifo_pop_o = !rst_i && !flush_i && !fifo_empty_i && (state_q == IDLE || (fire && last_o));
    state_d = state_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (fifo_pop_o) begin
      state_d = SERIAL;
      cnt_d = '0;
      hold_d = fifo_data_i;
    end else if (fire) begin
      state_d = last_o ? IDLE : SERIAL;
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: doc/fifo_pop_serializer.md
FIFO_POP_SERIALIZER -- requirements
Module: fifo_pop_serializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, meaning width of a word popped from the upstream FIFO.
REQ-002 SHALL have parameter OUT_WIDTH, default 8, meaning width of one output beat.
REQ-003 SHALL have parameter MSB_FIRST, default 1'b0, meaning 0 emits bits [OUT_WIDTH-1:0] first and 1 emits the top slice first.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port flush_i, input, 1, synchronous discard of the word in flight.
REQ-007 SHALL have port fifo_empty_i, input, 1, upstream FIFO empty flag.
REQ-008 SHALL have port fifo_data_i, input, IN_WIDTH, upstream FIFO head word, valid whenever fifo_empty_i=0.
REQ-009 SHALL have port fifo_pop_o, output, 1, pops the upstream FIFO head this cycle.
REQ-010 SHALL have port valid_o, input-facing output, 1, output beat valid.
REQ-011 SHALL have port ready_i, input, 1, downstream accepts the beat.
REQ-012 SHALL have port data_o, output, OUT_WIDTH, current beat.
REQ-013 SHALL have port last_o, output, 1, current beat is the final slice of its word.
REQ-014 SHALL have port busy_o, output, 1, a word is held (equals valid_o).

Function
REQ-015 SHALL derive RATIO = IN_WIDTH/OUT_WIDTH and a beat counter of width max(1,$clog2(RATIO)).
REQ-016 SHALL use two states: IDLE (no word held) and SERIAL (word held, beat counter valid).
REQ-017 SHALL assert fifo_pop_o combinationally iff fifo_empty_i=0 and flush_i=0 and (state=IDLE or (valid_o and ready_i and last_o)).
REQ-018 SHALL, on a pop, capture fifo_data_i into a holding register, clear the beat counter and enter SERIAL next cycle; pop-to-valid_o latency one cycle.
REQ-019 SHALL drive valid_o=1 exactly in SERIAL; data_o = slice[beat counter] (reversed order if MSB_FIRST).
REQ-020 SHALL hold data_o, last_o and the counter stable while valid_o=1 and ready_i=0.
REQ-021 SHALL increment the counter on valid_o and ready_i when not last; on the last beat accepted, go to IDLE unless a pop occurs the same cycle (back-to-back, no bubble, full rate).
REQ-022 SHALL assert last_o iff counter = RATIO-1; with RATIO=1 every beat is last and the block acts as a one-entry registered stage.
REQ-023 SHALL, on flush_i=1, go to IDLE and clear the counter next cycle regardless of ready_i, and not pop that cycle; flush has priority over handshake.
REQ-024 SHALL never pop when fifo_empty_i=1 and never pop twice for one word.
REQ-025 SHALL report a compile-time error if IN_WIDTH mod OUT_WIDTH != 0 or OUT_WIDTH=0.

Reset
REQ-026 SHALL, with rst_i=1 at a clock edge, enter IDLE, clear counter and holding register; valid_o=0, last_o=0, busy_o=0, data_o=0 after that edge.
REQ-027 SHALL keep fifo_pop_o=0 while rst_i=1, including reset asserted mid-word; the partial word is dropped.
REQ-028 SHALL give rst_i priority over flush_i and all handshakes.

Structure
REQ-029 SHALL place the state enum typedef (IDLE, SERIAL) in shared package cc_stream_pkg; RATIO and counter width stay local parameters.
REQ-030 SHALL be a single module with no sub-module instances; holding register and counter inline using the codebase register macros.

Verification
REQ-031 SHALL cover: FIFO holds 0xDDCCBBAA, ready_i=1, MSB_FIRST=0 -> beats AA,BB,CC,DD on 4 consecutive cycles, last_o only on DD, one pop.
REQ-032 SHALL cover: two words queued, ready_i=1 -> 8 beats on 8 consecutive cycles, second pop in the cycle DD accepted, no bubble.
REQ-033 SHALL cover: ready_i=0 for 3 cycles on beat BB -> data_o=BB stable, valid_o=1, no pop, counter unchanged.
REQ-034 SHALL cover: flush_i during beat CC -> valid_o=0 next cycle, no pop in flush cycle, next word restarts at its first slice.
REQ-035 SHALL cover: rst_i mid-word -> all outputs 0 next cycle, fifo_pop_o=0 throughout reset.
REQ-036 SHALL cover: RATIO=1 (IN_WIDTH=OUT_WIDTH=8), alternating ready_i -> each word emitted once with last_o=1, order preserved.
